mem_request_queue: RTL and testbench

//  Synchronous FIFO of memory-request records, used as one MSHR queue per outstanding line in the L1 data cache.
//  It buffers requests that target the same line, in arrival order, until the line returns from the lower level.
//  The oldest entry is always visible on req_out (show-ahead, first-word-fall-through).

---
 rtl/mem_request_queue.sv | 97 +++++++++
 tb/tb_mem_request_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_request_queue.sv
// mem_request_queue
//   Show-ahead FIFO of memory-request records. One instance serves as the
//   MSHR queue for a single outstanding L1 data-cache line: requests that
//   target the line are held in arrival order until the fill returns.
//
// Ports
//   clk_in       single clock, all state updates on the rising edge
//   rst_in       synchronous active-high reset; clears pointers and count
//   enqueue_in   push req_in at the tail
//   dequeue_in   pop the head entry
//   req_in       record to push (stored bit-exact, never interpreted)
//   cycle_count  global cycle counter; accepted, no functional effect
//   req_out      oldest entry, '0 when the queue is empty
//   empty        occupancy == 0
//   full         occupancy == QUEUE_SIZE
module mem_request_queue #(
  parameter int unsigned QUEUE_SIZE    = 16,
  parameter type         mem_request_t = logic [63:0]
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         enqueue_in,
  input  logic         dequeue_in,
  input  mem_request_t req_in,
  input  logic [31:0]  cycle_count,
  output mem_request_t req_out,
  output logic         empty,
  output logic         full
);

  // Counter/pointer width holds 0..QUEUE_SIZE; address width indexes storage.
  localparam int unsigned CW = $clog2(QUEUE_SIZE + 1);
  localparam int unsigned AW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(QUEUE_SIZE - 1);
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_SIZE);

  mem_request_t mem_q [QUEUE_SIZE];

  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic do_enq;
  logic do_deq;

  // Kept only so the counter input has a sink; it never reaches an output.
  logic unused_cycle_count;
  assign unused_cycle_count = ^cycle_count;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);

  // A pop is never granted on an empty queue, so there is no bypass path.
  // A push into a full queue is granted only when the head frees a slot
  // in the same cycle.
  assign do_deq = dequeue_in && !empty;
  assign do_enq = enqueue_in && (!full || dequeue_in);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_deq) begin
      head_d = (head_q == LAST) ? '0 : head_q + CW'(1);
    end
    if (do_enq) begin
      tail_d = (tail_q == LAST) ? '0 : tail_q + CW'(1);
    end
    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale contents are masked by the count.
  always_ff @(posedge clk_in) begin
    if (!rst_in && do_enq) begin
      mem_q[tail_q[AW-1:0]] <= req_in;
    end
  end

  assign req_out = empty ? '0 : mem_q[head_q[AW-1:0]];

endmodule

// File: tb/tb_mem_request_queue.sv
module tb_mem_request_queue;

  logic        clk_in;
  logic        rst_in;
  logic        enqueue_in;
  logic        dequeue_in;
  logic [63:0] req_in;
  logic [31:0] cycle_count;
  logic [63:0] req_out;
  logic        empty;
  logic        full;

  int checks;
  int errors;

  mem_request_queue #(
    .QUEUE_SIZE   (16),
    .mem_request_t(logic [63:0])
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .req_in     (req_in),
    .cycle_count(cycle_count),
    .req_out    (req_out),
    .empty      (empty),
    .full       (full)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic e, input logic d, input logic [63:0] data);
    rst_in      = r;
    enqueue_in  = e;
    dequeue_in  = d;
    req_in      = data;
    cycle_count = $urandom;
    @(posedge clk_in);
    #1;
    rst_in     = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_in      = 1'b0;
    enqueue_in  = 1'b0;
    dequeue_in  = 1'b0;
    req_in      = '0;
    cycle_count = '0;

    // 1: reset then idle
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full",  {63'd0, full},  64'd0);
    chk("rst_out",   req_out,        64'h0);

    // 2: three pushes, three pops
    step(1'b0, 1'b1, 1'b0, 64'hA1);
    chk("t2_head_a1", req_out,        64'hA1);
    chk("t2_empty0",  {63'd0, empty}, 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'hB2);
    step(1'b0, 1'b1, 1'b0, 64'hC3);
    chk("t2_head_still_a1", req_out, 64'hA1);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t2_pop1", req_out, 64'hB2);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t2_pop2", req_out, 64'hC3);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t2_pop3",   req_out,        64'h0);
    chk("t2_empty1", {63'd0, empty}, 64'd1);

    // 3: fill to 16, dropped 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'(i));
      chk("t3_full_flag", {63'd0, full}, (i == 15) ? 64'd1 : 64'd0);
    end
    step(1'b0, 1'b1, 1'b0, 64'h99);
    chk("t3_drop_full", {63'd0, full}, 64'd1);
    chk("t3_drop_head", req_out,       64'h0);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", req_out, 64'(i));
      step(1'b0, 1'b0, 1'b1, 64'h0);
    end
    chk("t3_empty", {63'd0, empty}, 64'd1);
    chk("t3_out0",  req_out,        64'h0);

    // 4: simultaneous push/pop while full, with tail wrap
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'(i));
    end
    chk("t4_full_before", {63'd0, full}, 64'd1);
    step(1'b0, 1'b1, 1'b1, 64'h55);
    chk("t4_full_kept", {63'd0, full}, 64'd1);
    chk("t4_head1",     req_out,       64'h1);
    for (int i = 1; i < 16; i++) begin
      chk("t4_drain", req_out, 64'(i));
      step(1'b0, 1'b0, 1'b1, 64'h0);
    end
    chk("t4_wrap_55", req_out, 64'h55);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t4_empty", {63'd0, empty}, 64'd1);

    // 5: simultaneous push/pop while empty, then pop on empty
    step(1'b0, 1'b1, 1'b1, 64'h77);
    chk("t5_out77", req_out,        64'h77);
    chk("t5_empty", {63'd0, empty}, 64'd0);
    chk("t5_full",  {63'd0, full},  64'd0);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t5_popped", {63'd0, empty}, 64'd1);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t5_pop_empty",     {63'd0, empty}, 64'd1);
    chk("t5_pop_empty_out", req_out,        64'h0);
    step(1'b0, 1'b1, 1'b0, 64'h88);
    chk("t5_after_underflow", req_out, 64'h88);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t5_single", {63'd0, empty}, 64'd1);

    // 6: reset wins over a concurrent enqueue
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h10 + 64'(i));
    end
    chk("t6_head10", req_out, 64'h10);
    step(1'b1, 1'b1, 1'b0, 64'hEE);
    chk("t6_rst_empty", {63'd0, empty}, 64'd1);
    chk("t6_rst_out",   req_out,        64'h0);
    chk("t6_rst_full",  {63'd0, full},  64'd0);
    step(1'b0, 1'b1, 1'b0, 64'h3C);
    chk("t6_out3c", req_out, 64'h3C);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    chk("t6_single_entry", {63'd0, empty}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
